if_stage: RTL

- Fetch stage of the 5-stage MIPS pipeline, directly upstream of the decode stage.
- Contains a pre-IF step that generates the next PC and issues it to a synchronous-read instruction SRAM (1-cycle read latency).
- The IF register holds the fetched PC and captures the returning instruction, with a one-entry skid buffer for it.
- Consumes the decode stage's branch bus, including its branch-stall flag, and presents {inst, pc} to decode under the valid/allowin handshake.

---
 rtl/if_stage.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/if_stage.sv
// ----------------------------------------------------------------------------
// if_stage : instruction fetch stage of a 5-stage MIPS pipeline.
//
// A pre-IF step picks the next PC and issues it to a synchronous-read
// instruction SRAM (data returns one cycle after the request). The IF
// register holds the fetched PC; the returning instruction is either passed
// straight through or parked in a one-entry skid buffer when decode is not
// ready. Branch redirects come from decode on br_bus; a redirect that cannot
// be issued immediately is remembered until the next issue.
//
// Ports:
//   clk              clock, all state updates on the rising edge
//   reset            synchronous, active-high reset
//   ds_allowin       decode can accept an instruction this cycle
//   br_bus           {br_stall, br_taken, br_target[31:0]} from decode
//   fs_to_ds_valid   IF holds a valid instruction for decode
//   fs_to_ds_bus     {fs_inst[31:0], fs_pc[31:0]}
//   inst_sram_en     SRAM read enable (one per issued fetch)
//   inst_sram_wen    SRAM byte write enables, always 4'h0
//   inst_sram_addr   fetch address
//   inst_sram_wdata  SRAM write data, always 32'h0
//   inst_sram_rdata  SRAM read data, valid the cycle after inst_sram_en
// ----------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC        = 32'hbfc00000,
  parameter int          BR_BUS_WD       = 34,
  parameter int          FS_TO_DS_BUS_WD = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ds_allowin,
  input  logic [BR_BUS_WD-1:0]       br_bus,
  output logic                       fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
  output logic                       inst_sram_en,
  output logic [3:0]                 inst_sram_wen,
  output logic [31:0]                inst_sram_addr,
  output logic [31:0]                inst_sram_wdata,
  input  logic [31:0]                inst_sram_rdata
);

  // Branch bus fields
  logic        br_stall;
  logic        br_taken;
  logic [31:0] br_target;

  assign br_stall  = br_bus[BR_BUS_WD-1];
  assign br_taken  = br_bus[BR_BUS_WD-2];
  assign br_target = br_bus[31:0];

  // State
  logic        fs_valid_q,    fs_valid_d;
  logic [31:0] fs_pc_q,       fs_pc_d;
  logic        issued_q,      issued_d;     // an SRAM response arrives this cycle
  logic        buf_valid_q,   buf_valid_d;
  logic [31:0] inst_buf_q,    inst_buf_d;
  logic        br_pending_q,  br_pending_d;
  logic [31:0] pend_target_q, pend_target_d;

  // Handshake and pre-IF
  logic        fs_ready_go;
  logic        fs_allowin;
  logic        to_fs_valid;
  logic        to_fs_ready_go;
  logic        issue;
  logic        br_now;
  logic        fs_xfer;
  logic [31:0] nextpc;
  logic [31:0] fs_inst;

  assign fs_ready_go    = 1'b1;
  assign fs_allowin     = ~fs_valid_q | (fs_ready_go & ds_allowin);
  assign to_fs_valid    = ~reset;
  assign to_fs_ready_go = ~br_stall;
  assign issue          = to_fs_valid & to_fs_ready_go & fs_allowin;

  // br_stall dominates br_taken: a stalled branch has not resolved yet.
  assign br_now = br_taken & ~br_stall;

  // A remembered redirect outranks a live one; otherwise fall through to the
  // sequential PC (32-bit wrap). fs_pc is the delay slot, so sequential
  // fetch after a not-yet-seen branch keeps the slot intact.
  assign nextpc = br_pending_q ? pend_target_q :
                  br_now       ? br_target     :
                                 fs_pc_q + 32'd4;

  // Gated by reset so decode never sees a stale instruction while reset is held.
  assign fs_to_ds_valid = fs_valid_q & fs_ready_go & ~reset;
  assign fs_xfer        = fs_to_ds_valid & ds_allowin;

  // The SRAM only guarantees its output for the single cycle after a read.
  assign fs_inst      = buf_valid_q ? inst_buf_q : inst_sram_rdata;
  assign fs_to_ds_bus = {fs_inst, fs_pc_q};

  assign inst_sram_en    = issue;
  assign inst_sram_addr  = nextpc;
  assign inst_sram_wen   = 4'h0;
  assign inst_sram_wdata = 32'h0;

  // NOTE: every signal gets a default before any branch, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    fs_valid_d    = fs_valid_q;
    fs_pc_d       = fs_pc_q;
    issued_d      = issue;
    buf_valid_d   = buf_valid_q;
    inst_buf_d    = inst_buf_q;
    br_pending_d  = br_pending_q;
    pend_target_d = pend_target_q;

    if (issue) begin
      fs_valid_d = 1'b1;
      fs_pc_d    = nextpc;
    end else if (fs_allowin) begin
      fs_valid_d = 1'b0;   // bubble: slot drained with nothing to refill it
    end

    // Capture the response in the only cycle it is guaranteed to be present
    // if decode is not taking it right now.
    if (fs_xfer) begin
      buf_valid_d = 1'b0;
    end else if (issued_q && fs_valid_q && !ds_allowin) begin
      buf_valid_d = 1'b1;
      inst_buf_d  = inst_sram_rdata;
    end

    if (issue) begin
      br_pending_d = 1'b0;
    end else if (br_now) begin
      br_pending_d  = 1'b1;
      pend_target_d = br_target;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      fs_valid_q   <= 1'b0;
      fs_pc_q      <= RESET_PC - 32'd4;
      issued_q     <= 1'b0;   // drops any SRAM response still in flight
      buf_valid_q  <= 1'b0;
      br_pending_q <= 1'b0;
    end else begin
      fs_valid_q   <= fs_valid_d;
      fs_pc_q      <= fs_pc_d;
      issued_q     <= issued_d;
      buf_valid_q  <= buf_valid_d;
      br_pending_q <= br_pending_d;
    end
  end

  // NOTE: payload registers are only read when their valid flag is set, so
  // they carry no reset.
  always_ff @(posedge clk) begin
    inst_buf_q    <= inst_buf_d;
    pend_target_q <= pend_target_d;
  end

endmodule
